// File: rtl/ahb_wait_mem_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed RAM.
// Inserts a fixed number of wait states per OKAY transfer and returns a
// two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
module ahb_wait_mem_subordinate #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MemDepth     = 1024,
  parameter int unsigned WaitStates   = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [AddressWidth-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DataWidth-1:0]    HWDATA,
  input  logic                    HREADYin,
  output logic [DataWidth-1:0]    HRDATA,
  output logic                    HRESP,
  output logic                    HREADYout
);

  localparam int unsigned BytesPerWord = DataWidth / 8;
  localparam int unsigned AddrLsb      = $clog2(BytesPerWord);
  localparam int unsigned IdxW         = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int unsigned ByteRange    = MemDepth * BytesPerWord;
  localparam int unsigned CntW         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Storage; deliberately not cleared by reset.
  logic [DataWidth-1:0] mem [MemDepth];

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [BytesPerWord-1:0] be_q, be_d;
  logic                    write_q, write_d;
  logic                    hready_q, hready_d;
  logic                    hresp_q, hresp_d;

  logic                    accept_c;
  logic [7:0]              size_bytes_c;
  logic                    oversize_c;
  logic                    misalign_c;
  logic                    range_c;
  logic                    err_c;
  logic [AddrLsb-1:0]      off_c;
  logic [IdxW-1:0]         idx_c;
  logic [BytesPerWord-1:0] be_c;
  logic                    unused_inputs_c;

  // Burst type and SEQ/NONSEQ distinction carry no meaning here.
  assign unused_inputs_c = ^{HBURST, HTRANS[0]};

  // Address-phase decode: acceptance, error classification, byte lanes.
  always_comb begin
    accept_c     = HSEL & HREADYin & HTRANS[1];
    size_bytes_c = 8'(1) << HSIZE;
    oversize_c   = 32'(size_bytes_c) > BytesPerWord;
    misalign_c   = (HADDR & AddressWidth'(size_bytes_c - 8'd1)) != '0;
    range_c      = 64'(HADDR) >= 64'(ByteRange);
    err_c        = oversize_c | misalign_c | range_c;
    off_c        = HADDR[AddrLsb-1:0];
    idx_c        = HADDR[AddrLsb +: IdxW];
    be_c         = '0;
    for (int unsigned b = 0; b < BytesPerWord; b++) begin
      be_c[b] = (b >= 32'(off_c)) && (b < 32'(off_c) + 32'(size_bytes_c));
    end
  end

  // Next-state logic; registered handshake outputs follow the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = ST_LAST;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        // IDLE, LAST and ERR2 all complete a data phase this cycle.
        if (accept_c) begin
          idx_d   = idx_c;
          be_d    = be_c;
          write_d = HWRITE;
          if (err_c) begin
            state_d = ST_ERR1;
          end else if (WaitStates == 0) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CntW'(WaitStates);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Byte-masked RAM write on the edge that ends the final write data phase.
  always_ff @(posedge HCLK) begin
    if ((state_q == ST_LAST) && write_q) begin
      for (int unsigned b = 0; b < BytesPerWord; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Read data is the full latched word, only while a read completes.
  always_comb begin
    HRDATA = '0;
    if ((state_q == ST_LAST) && !write_q) begin
      HRDATA = mem[idx_q];
    end
  end

  assign HREADYout = hready_q;
  assign HRESP     = hresp_q;

endmodule
